offset_encoder: RTL and testbench
=================================

OFFSET_ENCODER -- requirements
Module: offset_encoder

Interface
REQ-001 Parameter DATA_IN_MAX_WIDTH, default 12: width of the long (jump) offset field.
REQ-002 Parameter DATA_IN_MIN_WIDTH, default 8: width of the short (branch) offset field.
REQ-003 Parameter DATA_OUT_WIDTH, default 16: address/data width.
REQ-004 Parameter SHIFT_AMOUNT, default 1: offset scaling shift, log2 of instruction alignment.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-007 in_valid  input  1  request present on pc/target.
REQ-008 in_ready  output  1  encoder accepts a request this cycle.
REQ-009 pc  input  DATA_OUT_WIDTH  address of the branching instruction.
REQ-010 target  input  DATA_OUT_WIDTH  destination address.
REQ-011 out_valid  output  1  result present on output fields.
REQ-012 out_ready  input  1  downstream accepts the result this cycle.
REQ-013 off_max  output  DATA_IN_MAX_WIDTH  encoded long offset field.
REQ-014 off_min  output  DATA_IN_MIN_WIDTH  encoded short offset field.
REQ-015 fit_max / fit_min  output  1 each  displacement representable in the long / short field.
REQ-016 misaligned  output  1  displacement has a nonzero bit among its low SHIFT_AMOUNT bits.
REQ-017 err_count  output  8  saturating count of results delivered with fit_max=0 or misaligned=1.

Function
REQ-018 A transfer SHALL occur on an input when in_valid & in_ready, and on the output when out_valid & out_ready.
REQ-019 Stage 1 SHALL register diff = (target - pc) mod 2^DATA_OUT_WIDTH, interpreted as two's-complement signed.
REQ-020 Stage 2 SHALL register misaligned = |diff[SHIFT_AMOUNT-1:0]| and s = diff arithmetically shifted right by SHIFT_AMOUNT.
REQ-021 fit_max SHALL be 1 iff s lies in [-2^(DATA_IN_MAX_WIDTH-1), 2^(DATA_IN_MAX_WIDTH-1)-1]; fit_min likewise with DATA_IN_MIN_WIDTH.
REQ-022 off_max / off_min SHALL be the low DATA_IN_MAX_WIDTH / DATA_IN_MIN_WIDTH bits of s, regardless of fit flags.
REQ-023 Round-trip: when fit_max=1 and misaligned=0, sign-extending off_max to DATA_OUT_WIDTH and shifting left by SHIFT_AMOUNT SHALL reproduce diff; the same holds for off_min when fit_min=1.
REQ-024 Latency SHALL be exactly 2 cycles from input transfer to out_valid when out_ready is held high; throughput SHALL be one request per cycle.
REQ-025 in_ready SHALL be 1 when stage 1 is empty, or when stage 1 can advance because stage 2 is empty or transferring this cycle.
REQ-026 While out_valid=1 and out_ready=0, all output fields SHALL hold stable; no request SHALL be dropped or duplicated.
REQ-027 Simultaneous input and output transfers SHALL advance both stages in the same cycle.
REQ-028 err_count SHALL increment on each output transfer with fit_max=0 or misaligned=1, saturating at 255.
REQ-029 diff = 0 SHALL yield off_max=0, off_min=0, fit_max=1, fit_min=1, misaligned=0.

Reset
REQ-030 On rst_n low, the block SHALL immediately clear both stage-valid flags, out_valid and err_count, and force all data outputs to 0.
REQ-031 A reset asserted mid-operation SHALL discard in-flight requests; in_ready SHALL be 1 on the first cycle after rst_n rises.

Structure
REQ-032 The field-width and shift constants SHALL live in the shared ISA package used by sign_extend_shifter, so that encoder and decoder field widths cannot diverge.
REQ-033 The range check SHALL be a single sub-module, signed_fit_check, parameterised by field width and instantiated twice.

Verification
REQ-034 pc=0x0100, target=0x0110 -> diff 0x0010, off_max=0x008, off_min=0x08, fit_max=1, fit_min=1, misaligned=0, two cycles after acceptance.
REQ-035 pc=0x0200, target=0x0100 -> off_max=0xF80, off_min=0x80, fit_max=1, fit_min=1 (s=-128); target=0x00FE -> fit_min=0, fit_max=1.
REQ-036 pc=0x0000, target=0x1000 -> s=2048, fit_max=0, err_count increments by 1; pc=0x0000, target=0x0003 -> misaligned=1.
REQ-037 Back-to-back stream of 10 requests with out_ready toggling every cycle -> all 10 results delivered in order, none lost, outputs stable during stalls.
REQ-038 Reset asserted while 2 requests are in flight -> out_valid=0 immediately, err_count=0, no stale result emitted after release.
REQ-039 300 out-of-range requests -> err_count saturates at 255; random fitting, aligned requests pass the REQ-023 round trip through sign_extend_shifter.

Source files
------------

// File: rtl/offset_encoder_pkg.sv
// Shared ISA constants for branch/jump offset fields, plus the decoder-side
// sign-extend-and-shift helper that turns an encoded field back into a displacement.
package offset_encoder_pkg;

    localparam int ISA_DATA_WIDTH = 16;
    localparam int ISA_MAX_WIDTH  = 12;
    localparam int ISA_MIN_WIDTH  = 8;
    localparam int ISA_SHIFT      = 1;

    function automatic logic [ISA_DATA_WIDTH-1:0] sign_extend_shifter(
        input logic [ISA_DATA_WIDTH-1:0] field,
        input int                        width
    );
        logic [ISA_DATA_WIDTH-1:0] ext;
        ext = field;
        for (int i = 0; i < ISA_DATA_WIDTH; i++) begin
            if (i >= width) ext[i] = field[width-1];
        end
        return ext << ISA_SHIFT;
    endfunction

endpackage

// File: rtl/signed_fit_check.sv
// Reports whether a signed value survives truncation to FIELD_WIDTH bits.
module signed_fit_check
    import offset_encoder_pkg::*;
#(
    parameter int VALUE_WIDTH = ISA_DATA_WIDTH,
    parameter int FIELD_WIDTH = ISA_MIN_WIDTH
) (
    input  logic [VALUE_WIDTH-1:0] value,
    output logic                   fit
);

    generate
        if (FIELD_WIDTH >= VALUE_WIDTH) begin : g_wide
            assign fit = (value == value);
        end else begin : g_narrow
            logic [VALUE_WIDTH-1:0] ext;
            // A value fits exactly when re-sign-extending its low bits gives it back.
            assign ext = {{(VALUE_WIDTH-FIELD_WIDTH){value[FIELD_WIDTH-1]}}, value[FIELD_WIDTH-1:0]};
            assign fit = (ext == value);
        end
    endgenerate

endmodule

// File: rtl/offset_encoder.sv
// Two-stage elastic pipeline encoding (target - pc) into long/short offset fields
// with range/alignment flags and a saturating error counter.
module offset_encoder
    import offset_encoder_pkg::*;
#(
    parameter int DATA_IN_MAX_WIDTH = ISA_MAX_WIDTH,
    parameter int DATA_IN_MIN_WIDTH = ISA_MIN_WIDTH,
    parameter int DATA_OUT_WIDTH    = ISA_DATA_WIDTH,
    parameter int SHIFT_AMOUNT      = ISA_SHIFT
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_OUT_WIDTH-1:0]    pc,
    input  logic [DATA_OUT_WIDTH-1:0]    target,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_IN_MAX_WIDTH-1:0] off_max,
    output logic [DATA_IN_MIN_WIDTH-1:0] off_min,
    output logic                         fit_max,
    output logic                         fit_min,
    output logic                         misaligned,
    output logic [7:0]                   err_count
);

    logic                             s1_valid;
    logic [DATA_OUT_WIDTH-1:0]        diff_reg;
    logic                             s2_advance;
    logic signed [DATA_OUT_WIDTH-1:0] s_next;
    logic                             fit_max_next;
    logic                             fit_min_next;
    logic                             misaligned_next;

    // Stage 2 can take new data when empty or emptying this cycle.
    assign s2_advance = !out_valid || out_ready;
    assign in_ready   = !s1_valid || s2_advance;

    assign s_next = $signed(diff_reg) >>> SHIFT_AMOUNT;

    generate
        if (SHIFT_AMOUNT > 0) begin : g_align
            assign misaligned_next = |diff_reg[SHIFT_AMOUNT-1:0];
        end else begin : g_no_align
            assign misaligned_next = 1'b0;
        end
    endgenerate

    signed_fit_check #(
        .VALUE_WIDTH(DATA_OUT_WIDTH),
        .FIELD_WIDTH(DATA_IN_MAX_WIDTH)
    ) u_fit_max (
        .value(s_next),
        .fit  (fit_max_next)
    );

    signed_fit_check #(
        .VALUE_WIDTH(DATA_OUT_WIDTH),
        .FIELD_WIDTH(DATA_IN_MIN_WIDTH)
    ) u_fit_min (
        .value(s_next),
        .fit  (fit_min_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            diff_reg <= '0;
        end else if (in_valid && in_ready) begin
            s1_valid <= 1'b1;
            diff_reg <= target - pc;
        end else if (s2_advance) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            off_max    <= '0;
            off_min    <= '0;
            fit_max    <= 1'b0;
            fit_min    <= 1'b0;
            misaligned <= 1'b0;
        end else if (s2_advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                off_max    <= s_next[DATA_IN_MAX_WIDTH-1:0];
                off_min    <= s_next[DATA_IN_MIN_WIDTH-1:0];
                fit_max    <= fit_max_next;
                fit_min    <= fit_min_next;
                misaligned <= misaligned_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= 8'd0;
        end else if (out_valid && out_ready && (!fit_max || misaligned) && (err_count != 8'hFF)) begin
            err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_offset_encoder.sv
// Directed bench for offset_encoder: known vectors, stalled stream, reset mid-flight,
// counter saturation and round trip of random fitting offsets.
module tb_offset_encoder;
    import offset_encoder_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] pc;
    logic [15:0] target;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] off_max;
    logic [7:0]  off_min;
    logic        fit_max;
    logic        fit_min;
    logic        misaligned;
    logic [7:0]  err_count;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    offset_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .pc        (pc),
        .target    (target),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .off_max   (off_max),
        .off_min   (off_min),
        .fit_max   (fit_max),
        .fit_min   (fit_min),
        .misaligned(misaligned),
        .err_count (err_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request with out_ready high and confirm the 2-cycle latency.
    task automatic send_and_get(input logic [15:0] p, input logic [15:0] t);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        pc        = p;
        target    = t;
        #1;
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        check("latency_c1", {31'd0, out_valid}, 32'd0);
        tick();
        check("latency_c2", {31'd0, out_valid}, 32'd1);
        $display("req pc=%h target=%h -> off_max=%h off_min=%h fit_max=%b fit_min=%b mis=%b err=%0d",
                 p, t, off_max, off_min, fit_max, fit_min, misaligned, err_count);
    endtask

    initial begin
        int          sent;
        int          recv;
        int          cyc;
        int          sval;
        logic [31:0] expv;
        logic [15:0] diff;
        logic [15:0] rt;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        pc        = '0;
        target    = '0;
        #2;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_off_max", {20'd0, off_max}, 32'd0);
        check("rst_off_min", {24'd0, off_min}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Small forward branch
        send_and_get(16'h0100, 16'h0110);
        check("fwd_off_max", {20'd0, off_max}, 32'h008);
        check("fwd_off_min", {24'd0, off_min}, 32'h08);
        check("fwd_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b110);
        tick();
        check("fwd_drained", {31'd0, out_valid}, 32'd0);

        // Most negative short offset
        send_and_get(16'h0200, 16'h0100);
        check("neg_off_max", {20'd0, off_max}, 32'hF80);
        check("neg_off_min", {24'd0, off_min}, 32'h80);
        check("neg_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b110);
        tick();

        // One past short range
        send_and_get(16'h0200, 16'h00FE);
        check("short_oor_off_max", {20'd0, off_max}, 32'hF7F);
        check("short_oor_off_min", {24'd0, off_min}, 32'h7F);
        check("short_oor_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b100);
        tick();
        check("short_oor_err", {24'd0, err_count}, 32'd0);

        // Zero displacement
        send_and_get(16'h1234, 16'h1234);
        check("zero_fields", {off_max, off_min}, 32'd0);
        check("zero_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b110);
        tick();

        // One past long range
        send_and_get(16'h0000, 16'h1000);
        check("long_oor_off_max", {20'd0, off_max}, 32'h800);
        check("long_oor_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b000);
        tick();
        check("long_oor_err", {24'd0, err_count}, 32'd1);

        // Odd displacement
        send_and_get(16'h0000, 16'h0003);
        check("mis_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b111);
        check("mis_off_min", {24'd0, off_min}, 32'h01);
        tick();
        check("mis_err", {24'd0, err_count}, 32'd2);

        // Stream of 10 with out_ready toggling; s = i - 3
        sent = 0;
        recv = 0;
        cyc  = 0;
        while (recv < 10 && cyc < 100) begin
            out_ready = cyc[0];
            in_valid  = (sent < 10);
            pc        = 16'h0400 + 16'(sent * 32);
            target    = 16'h0400 + 16'(sent * 32) + 16'(sent * 2 - 6);
            #1;
            if (out_valid) begin
                expv = 32'(recv - 3);
                check("stream_off_max", {20'd0, off_max}, expv & 32'hFFF);
                check("stream_off_min", {24'd0, off_min}, expv & 32'hFF);
            end
            if (out_valid && out_ready) begin
                $display("stream result %0d off_max=%h off_min=%h", recv, off_max, off_min);
                recv++;
            end
            if (in_valid && in_ready) sent++;
            tick();
            cyc++;
        end
        in_valid = 1'b0;
        check("stream_count", 32'(recv), 32'd10);
        check("stream_err", {24'd0, err_count}, 32'd2);

        // Reset with two requests in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        pc        = 16'h0000;
        target    = 16'h0020;
        tick();
        target    = 16'h0040;
        tick();
        in_valid = 1'b0;
        check("pre_rst_valid", {31'd0, out_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_err", {24'd0, err_count}, 32'd0);
        check("midrst_off_max", {20'd0, off_max}, 32'd0);
        #2;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        tick();
        check("post_rst_ready", {31'd0, in_ready}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            check("post_rst_no_stale", {31'd0, out_valid}, 32'd0);
            tick();
        end

        // 300 out-of-range requests back to back
        in_valid = 1'b1;
        pc       = 16'h0000;
        target   = 16'h1000;
        repeat (300) tick();
        in_valid = 1'b0;
        repeat (3) tick();
        check("err_saturated", {24'd0, err_count}, 32'd255);
        $display("saturation err_count=%0d", err_count);

        // Random fitting, aligned requests round-trip through the decoder helper
        for (int n = 0; n < 16; n++) begin
            sval = int'($urandom_range(0, 255)) - 128;
            diff = 16'(sval * 2);
            send_and_get(16'($urandom_range(0, 65535)), 16'h0000);
            tick();
            pc = 16'($urandom_range(0, 65535));
            send_and_get(pc, pc + diff);
            check("rt_flags", {29'd0, fit_max, fit_min, misaligned}, 32'b110);
            rt = {{8{off_min[7]}}, off_min} << 1;
            check("rt_min_manual", {16'd0, rt}, {16'd0, diff});
            check("rt_max_helper", {16'd0, sign_extend_shifter({4'd0, off_max}, ISA_MAX_WIDTH)}, {16'd0, diff});
            check("rt_min_helper", {16'd0, sign_extend_shifter({8'd0, off_min}, ISA_MIN_WIDTH)}, {16'd0, diff});
            tick();
        end
        check("err_hold", {24'd0, err_count}, 32'd255);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
